// File: rtl/handshake_pkg.sv
// Shared constants and elaboration helpers for the handshake pipeline chain.
// Kept free of logic so any block in the slice can import it.
package handshake_pkg;

   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic bit cfg_ok(input int stages, input int skid);
      return (stages >= STAGES_MIN) && (stages <= STAGES_MAX) && (skid == 0 || skid == 1);
   endfunction

endpackage

// File: rtl/handshake_stage.sv
// One valid/ready register stage; adds INC to each beat it takes in.
// Ready is recomputed locally so no ready signal has to leave the stage.
module handshake_stage #(
   parameter int DW  = 8,
   parameter int INC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          prev_valid,
   input  logic [DW-1:0] prev_data,
   input  logic          next_ready,
   output logic          valid,
   output logic [DW-1:0] data
);

   logic ready;

   assign ready = ~valid | next_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        valid <= 1'b0;
      else if (flush) valid <= 1'b0;
      else if (ready) valid <= prev_valid;
   end

   // Data is a don't-care once flushed, so it ignores flush and only moves on a real transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      data <= '0;
      else if (prev_valid & ready)  data <= prev_data + DW'(INC);
   end

endmodule

// File: rtl/handshake_pip_chain.sv
// Back-pressurable incrementing pipeline with optional input skid entry,
// synchronous flush and a registered occupancy count.
module handshake_pip_chain
   import handshake_pkg::*;
#(
   parameter int DW     = 8,
   parameter int STAGES = 4,
   parameter int INC    = 1,
   parameter int SKID   = 1,
   parameter int OW     = clog2(STAGES + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [OW-1:0] occupancy
);

   if (!cfg_ok(STAGES, SKID)) begin : g_bad_cfg
      $error("handshake_pip_chain: STAGES must be 1..16 and SKID 0..1");
   end

   // Entry 0 is the stage-0 feed; entry i+1 is the output register of stage i.
   logic [STAGES:0]         vld_pipe;
   logic [STAGES:0][DW-1:0] dat_pipe;
   logic                    ready0;
   logic                    accept;
   logic                    deliver;

   // Closed form of the ready chain: a stage can move unless it and everything after it is full and stalled.
   assign ready0 = m_ready | ~(&vld_pipe[STAGES:1]);

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic next_ready;
      if (i == STAGES - 1) begin : g_last
         assign next_ready = m_ready;
      end else begin : g_mid
         assign next_ready = m_ready | ~(&vld_pipe[STAGES:i+2]);
      end

      handshake_stage #(
         .DW  (DW),
         .INC (INC)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .prev_valid (vld_pipe[i]),
         .prev_data  (dat_pipe[i]),
         .next_ready (next_ready),
         .valid      (vld_pipe[i+1]),
         .data       (dat_pipe[i+1])
      );
   end

   if (SKID == 1) begin : g_skid
      logic          sk_valid;
      logic [DW-1:0] sk_data;

      // A full skid entry takes precedence so beats leave in arrival order.
      assign s_ready     = ~sk_valid;
      assign vld_pipe[0] = sk_valid | s_valid;
      assign dat_pipe[0] = sk_valid ? sk_data : s_data;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sk_valid <= 1'b0;
            sk_data  <= '0;
         end else if (flush) begin
            sk_valid <= 1'b0;
         end else if (sk_valid) begin
            if (ready0) sk_valid <= 1'b0;
         end else if (s_valid & ~ready0) begin
            sk_valid <= 1'b1;
            sk_data  <= s_data;
         end
      end
   end else begin : g_noskid
      assign s_ready     = ready0;
      assign vld_pipe[0] = s_valid;
      assign dat_pipe[0] = s_data;
   end

   assign m_valid = vld_pipe[STAGES];
   assign m_data  = dat_pipe[STAGES];
   assign accept  = s_valid & s_ready;
   assign deliver = m_valid & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     occupancy <= '0;
      else if (flush)              occupancy <= '0;
      else if (accept & ~deliver)  occupancy <= occupancy + OW'(1);
      else if (~accept & deliver)  occupancy <= occupancy - OW'(1);
   end

endmodule

// File: tb/tb_handshake_pip_chain.sv
// Directed bench: single-beat latency table, then backpressure, streaming,
// flush and reset sequences checked against a reference queue.
module tb_handshake_pip_chain;

   logic       clk = 1'b0;
   logic       rst, flush, s_valid, m_ready;
   logic [7:0] s_data;
   logic       s_ready, m_valid;
   logic [7:0] m_data;
   logic [2:0] occupancy;
   logic       s_ready3, m_valid3;
   logic [7:0] m_data3;
   logic [2:0] occ3;
   logic       s_ready_ns, m_valid_ns;
   logic [7:0] m_data_ns;
   logic [2:0] occ_ns;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   handshake_pip_chain #(.DW(8), .STAGES(4), .INC(1), .SKID(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy));

   handshake_pip_chain #(.DW(8), .STAGES(4), .INC(3), .SKID(1)) dut_inc3 (
      .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
      .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .occupancy(occ3));

   handshake_pip_chain #(.DW(8), .STAGES(4), .INC(1), .SKID(0)) dut_ns (
      .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready_ns), .s_data(s_data),
      .m_valid(m_valid_ns), .m_ready(m_ready), .m_data(m_data_ns), .occupancy(occ_ns));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model for the INC=1 instance
   logic [7:0] exp_q[$];
   int         occ_exp = 0;
   logic       hold_chk = 1'b0;
   logic [7:0] hold_d;
   logic       last_acc, last_del;
   logic [7:0] last_del_data;
   int         n_acc = 0, n_del = 0;

   task automatic tick();
      logic acc, del;
      @(negedge clk);
      acc = s_valid & s_ready;
      del = m_valid & m_ready;
      if (hold_chk) chk("hold_data", {24'd0, m_data}, {24'd0, hold_d});
      if (del) begin
         last_del_data = m_data;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_beat: got beat 0x%0h, expected no beat", m_data);
         end else begin
            chk("order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
         end
      end
      if (acc) exp_q.push_back(s_data + 8'd4);
      hold_chk = m_valid & ~m_ready;
      hold_d   = m_data;
      @(posedge clk);
      #1;
      if (flush) begin
         exp_q.delete();
         occ_exp  = 0;
         hold_chk = 1'b0;
      end else begin
         occ_exp = occ_exp + int'(acc) - int'(del);
      end
      if (acc) n_acc++;
      if (del) n_del++;
      last_acc = acc;
      last_del = del;
      chk("occupancy", {29'd0, occupancy}, occ_exp);
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp1;
      logic [7:0] exp3;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'h10, 8'h14, 8'h1C};
      vecs[1] = '{8'hFE, 8'h02, 8'h0A};
      vecs[2] = '{8'h00, 8'h04, 8'h0C};
      vecs[3] = '{8'hFF, 8'h03, 8'h0B};
      vecs[4] = '{8'hFC, 8'h00, 8'h08};
      vecs[5] = '{8'h7F, 8'h83, 8'h8B};

      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = 8'h00;
      #12;
      chk("rst_m_valid", {31'd0, m_valid}, 0);
      chk("rst_m_data", {24'd0, m_data}, 0);
      chk("rst_occupancy", {29'd0, occupancy}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_s_ready", {31'd0, s_ready}, 1);
      chk("rst_s_ready_inc3", {31'd0, s_ready3}, 1);

      // Single beats: presented in cycle 0, m_valid first seen in cycle 4.
      for (int v = 0; v < 6; v++) begin
         s_valid = 1'b1; s_data = vecs[v].din;
         tick();
         s_valid = 1'b0;
         chk("lat_accept", {31'd0, last_acc}, 1);
         chk("lat_occ_one", {29'd0, occupancy}, 1);
         for (int c = 1; c < 4; c++) begin
            chk("lat_early", {31'd0, m_valid}, 0);
            tick();
         end
         chk("lat_m_valid", {31'd0, m_valid}, 1);
         chk("lat_m_valid_inc3", {31'd0, m_valid3}, 1);
         chk("data_inc1", {24'd0, m_data}, {24'd0, vecs[v].exp1});
         chk("data_inc3", {24'd0, m_data3}, {24'd0, vecs[v].exp3});
         tick();
         chk("lat_drained", {31'd0, m_valid}, 0);
      end

      // Backpressure: 7 beats against a stalled sink.
      begin
         int idx;
         int dels;
         idx = 0;
         m_ready = 1'b0;
         for (int c = 0; c < 7; c++) begin
            s_valid = 1'b1; s_data = idx[7:0];
            tick();
            if (last_acc) idx++;
         end
         chk("bp_accepted", idx, 5);
         chk("bp_occupancy", {29'd0, occupancy}, 5);
         chk("bp_s_ready_low", {31'd0, s_ready}, 0);
         m_ready = 1'b1;
         dels = 0;
         for (int c = 0; c < 5; c++) begin
            if (idx < 7) begin s_valid = 1'b1; s_data = idx[7:0]; end
            else s_valid = 1'b0;
            tick();
            if (last_acc) idx++;
            if (last_del) dels++;
         end
         chk("bp_back_to_back", dels, 5);
         for (int c = 0; c < 8; c++) begin
            if (idx < 7) begin s_valid = 1'b1; s_data = idx[7:0]; end
            else s_valid = 1'b0;
            tick();
            if (last_acc) idx++;
         end
         chk("bp_all_accepted", idx, 7);
         chk("bp_drained", exp_q.size(), 0);
      end

      // Streaming with toggling sink.
      begin
         int seq;
         seq = 8'h40;
         for (int c = 0; c < 40; c++) begin
            s_valid = 1'b1; s_data = seq[7:0];
            m_ready = (c % 2 == 0);
            tick();
            if (last_acc) seq++;
         end
         s_valid = 1'b0; m_ready = 1'b1;
         for (int c = 0; c < 8; c++) tick();
         chk("stream_drained", exp_q.size(), 0);
         chk("stream_balance", n_acc, n_del);
         chk("stream_progress", (seq > 8'h50), 1);
      end

      // Flush with 3 beats held plus one offered on the flush cycle.
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         s_valid = 1'b1; s_data = 8'h60 + 8'(c);
         tick();
      end
      chk("flush_pre_occ", {29'd0, occupancy}, 3);
      flush = 1'b1; s_data = 8'h70;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      chk("flush_occ", {29'd0, occupancy}, 0);
      chk("flush_m_valid", {31'd0, m_valid}, 0);
      begin
         int d0;
         m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h20;
         d0 = n_del;
         tick();
         s_valid = 1'b0;
         for (int c = 0; c < 6; c++) tick();
         chk("flush_one_beat", n_del - d0, 1);
         chk("flush_fresh_data", {24'd0, last_del_data}, 8'h24);
      end

      // Asynchronous reset mid-stream.
      m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h40;
      for (int c = 0; c < 4; c++) tick();
      s_valid = 1'b0;
      chk("rst_pre_occ", {29'd0, occupancy}, 4);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_m_valid", {31'd0, m_valid}, 0);
      chk("arst_m_data", {24'd0, m_data}, 0);
      chk("arst_occupancy", {29'd0, occupancy}, 0);
      exp_q.delete(); occ_exp = 0; hold_chk = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("arst_s_ready", {31'd0, s_ready}, 1);
      begin
         int d0;
         m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h50;
         d0 = n_del;
         tick();
         s_valid = 1'b0;
         for (int c = 0; c < 6; c++) tick();
         chk("arst_resume", n_del - d0, 1);
         chk("arst_resume_data", {24'd0, last_del_data}, 8'h54);
      end

      // Combinational s_ready instance, driven full.
      m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h30;
      for (int c = 0; c < 6; c++) tick();
      chk("ns_occupancy", {29'd0, occ_ns}, 4);
      chk("ns_m_valid", {31'd0, m_valid_ns}, 1);
      chk("ns_m_data", {24'd0, m_data_ns}, 8'h34);
      chk("ns_s_ready_full", {31'd0, s_ready_ns}, 0);
      m_ready = 1'b1;
      #1;
      chk("ns_s_ready_comb", {31'd0, s_ready_ns}, 1);
      s_valid = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      chk("final_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
